// File: rtl/simple_dut_pkg.sv
// Shared types for the simple-DUT packet accumulator.
// Opcodes, FSM states and default widths.
package simple_dut_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [7:0] {
        OP_SUM = 8'd0,
        OP_XOR = 8'd1,
        OP_MAX = 8'd2
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH
    } state_e;

endpackage

// File: rtl/simple_dut_reduce.sv
// Combinational reduction step for the accumulator.
// Folds one beat into the running value and flags SUM carry.
module simple_dut_reduce
    import simple_dut_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] acc_nxt,
    output logic              ovf
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, data};

    // Select the reduced value for the latched opcode.
    always_comb begin
        acc_nxt = acc;
        ovf     = 1'b0;
        case (op)
            OP_SUM: begin
                acc_nxt = sum[DATA_W-1:0];
                ovf     = sum[DATA_W];
            end
            OP_XOR: acc_nxt = acc ^ data;
            OP_MAX: acc_nxt = (data > acc) ? data : acc;
            default: acc_nxt = acc;
        endcase
    end

endmodule

// File: rtl/simple_dut_accum.sv
// Packet accumulator: reduces valid beats until last,
// then emits one registered result pulse per packet.
module simple_dut_accum
    import simple_dut_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bitSignal1,
    input  logic              i_bitSignal2,
    input  logic [DATA_W-1:0] i_bit32Signal1,
    input  logic [7:0]        i_bit8Signal2,
    output logic              o_bitSignal1,
    output logic              o_bitSignal2,
    output logic [DATA_W-1:0] o_bit32Signal1,
    output logic [CNT_W-1:0]  o_bit8Signal2
);

    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_BEATS);
    localparam logic [7:0]       OPHI = 8'(OP_MAX);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_sat;
    logic                err_q, err_d;
    logic [7:0]          op_q, op_d;
    logic                fin;
    logic [DATA_W-1:0]   red_acc;
    logic                red_ovf;
    logic                op_bad;

    simple_dut_reduce #(.DATA_W(DATA_W)) u_reduce (
        .op      (op_q),
        .acc     (acc_q),
        .data    (i_bit32Signal1),
        .acc_nxt (red_acc),
        .ovf     (red_ovf)
    );

    assign cnt_sat = (cnt_q >= MAXC) ? MAXC : cnt_q + CNT_W'(1);
    assign op_bad  = i_bit8Signal2 > OPHI;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and next packet context for the current beat.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        op_d    = op_q;
        fin     = 1'b0;
        if (i_bitSignal1) begin
            unique case (state_q)
                IDLE: begin
                    op_d    = i_bit8Signal2;
                    acc_d   = i_bit32Signal1;
                    cnt_d   = CNT_W'(1);
                    err_d   = op_bad;
                    state_d = op_bad ? FLUSH : ACCUM;
                end
                ACCUM: begin
                    if (i_bit8Signal2 != op_q || cnt_q >= MAXC) begin
                        err_d   = 1'b1;
                        cnt_d   = cnt_sat;
                        state_d = FLUSH;
                    end else begin
                        acc_d = red_acc;
                        cnt_d = cnt_q + CNT_W'(1);
                        err_d = err_q | red_ovf;
                    end
                end
                FLUSH: cnt_d = cnt_sat;
                default: state_d = IDLE;
            endcase
            if (i_bitSignal2) begin
                fin     = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // Packet context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            op_q  <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            op_q  <= op_d;
        end
    end

    // Result registers: pulse valid, hold data until next packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_bitSignal1   <= 1'b0;
            o_bitSignal2   <= 1'b0;
            o_bit32Signal1 <= '0;
            o_bit8Signal2  <= '0;
        end else begin
            o_bitSignal1 <= fin;
            if (fin) begin
                o_bitSignal2   <= err_d;
                o_bit32Signal1 <= acc_d;
                o_bit8Signal2  <= cnt_d;
            end
        end
    end

endmodule

// File: tb/tb_simple_dut_accum.sv
// Bench for simple_dut_accum: packet-level model,
// per-cycle compare, directed literals and random packets.
module tb_simple_dut_accum;

    localparam int MB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        v, l;
    logic [31:0] d;
    logic [7:0]  op;
    logic        o_v, o_e;
    logic [31:0] o_r;
    logic [7:0]  o_c;

    int errors = 0;
    int checks = 0;
    bit en = 1'b0;

    logic [31:0] qd[$];
    logic [7:0]  qo[$];
    logic        m_v = 1'b0;
    logic        m_e = 1'b0;
    logic [31:0] m_r = '0;
    logic [7:0]  m_c = '0;

    always #5 clk = ~clk;

    simple_dut_accum #(
        .DATA_W    (32),
        .CNT_W     (8),
        .MAX_BEATS (MB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_bitSignal1   (v),
        .i_bitSignal2   (l),
        .i_bit32Signal1 (d),
        .i_bit8Signal2  (op),
        .o_bitSignal1   (o_v),
        .o_bitSignal2   (o_e),
        .o_bit32Signal1 (o_r),
        .o_bit8Signal2  (o_c)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Whole-packet reduction from the beat list.
    function automatic void reduce_pkt(output logic [31:0] r,
                                       output logic [7:0] c,
                                       output logic e);
        int n;
        logic [7:0] o0;
        logic [32:0] s;
        bit frozen;
        n  = qd.size();
        o0 = qo[0];
        r  = qd[0];
        e  = (o0 > 8'd2);
        frozen = e;
        c = (n > MB) ? 8'(MB) : 8'(n);
        for (int i = 1; i < n; i++) begin
            if (!frozen) begin
                if (qo[i] != o0 || i >= MB) begin
                    e = 1'b1;
                    frozen = 1'b1;
                end else if (o0 == 8'd0) begin
                    s = {1'b0, r} + {1'b0, qd[i]};
                    if (s[32]) e = 1'b1;
                    r = s[31:0];
                end else if (o0 == 8'd1) begin
                    r = r ^ qd[i];
                end else begin
                    if (qd[i] > r) r = qd[i];
                end
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qd.delete();
            qo.delete();
            m_v = 1'b0;
            m_e = 1'b0;
            m_r = '0;
            m_c = '0;
        end else begin
            m_v = 1'b0;
            if (v) begin
                qd.push_back(d);
                qo.push_back(op);
                if (l) begin
                    reduce_pkt(m_r, m_c, m_e);
                    m_v = 1'b1;
                    qd.delete();
                    qo.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            check("pulse", {31'b0, o_v}, {31'b0, m_v});
            check("result", o_r, m_r);
            check("count", {24'b0, o_c}, {24'b0, m_c});
            check("err", {31'b0, o_e}, {31'b0, m_e});
        end
    end

    task automatic nxt(input logic vv, input logic [7:0] o,
                       input logic [31:0] dd, input logic ll);
        #1;
        v  = vv;
        op = o;
        d  = dd;
        l  = ll;
    endtask

    task automatic beat(input logic [7:0] o, input logic [31:0] dd,
                        input logic ll);
        @(negedge clk);
        nxt(1'b1, o, dd, ll);
    endtask

    task automatic idle();
        @(negedge clk);
        nxt(1'b0, 8'($urandom), $urandom, 1'($urandom));
    endtask

    task automatic expect_lit(input string nm, input logic [31:0] r,
                              input logic [7:0] c, input logic e);
        @(negedge clk);
        check({nm, ".v"}, {31'b0, o_v}, 32'd1);
        check({nm, ".r"}, o_r, r);
        check({nm, ".c"}, {24'b0, o_c}, {24'b0, c});
        check({nm, ".e"}, {31'b0, o_e}, {31'b0, e});
        check({nm, ".model"}, m_r, r);
    endtask

    initial begin
        int n;
        logic [7:0] o0, oi;
        logic [31:0] di;
        rst = 1'b1;
        v = 1'b0; l = 1'b0; d = '0; op = '0;
        #2;
        check("rst.v", {31'b0, o_v}, 32'd0);
        check("rst.r", o_r, 32'd0);
        check("rst.c", {24'b0, o_c}, 32'd0);
        @(posedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;

        beat(8'd0, 32'd1, 1'b0);
        beat(8'd0, 32'd2, 1'b0);
        beat(8'd0, 32'd3, 1'b1);
        expect_lit("sum3", 32'd6, 8'd3, 1'b0);
        nxt(1'b0, 8'd0, 32'd0, 1'b0);

        beat(8'd1, 32'hA5A5A5A5, 1'b1);
        expect_lit("xor1", 32'hA5A5A5A5, 8'd1, 1'b0);
        nxt(1'b0, 8'd0, 32'd0, 1'b0);

        beat(8'd0, 32'hFFFFFFFF, 1'b0);
        beat(8'd0, 32'd2, 1'b1);
        expect_lit("ovf", 32'd1, 8'd2, 1'b1);
        nxt(1'b0, 8'd0, 32'd0, 1'b0);

        beat(8'd2, 32'd5, 1'b0);
        idle();
        beat(8'd2, 32'd9, 1'b0);
        idle();
        idle();
        beat(8'd2, 32'd7, 1'b1);
        expect_lit("max", 32'd9, 8'd3, 1'b0);
        nxt(1'b1, 8'd0, 32'd4, 1'b1);
        expect_lit("b2b", 32'd4, 8'd1, 1'b0);
        nxt(1'b0, 8'd0, 32'd0, 1'b0);

        beat(8'd0, 32'd1, 1'b0);
        beat(8'd1, 32'd2, 1'b0);
        for (int i = 0; i < 10; i++)
            beat(8'd0, 32'd5, (i == 9));
        expect_lit("opchg", 32'd1, 8'd12, 1'b1);
        nxt(1'b0, 8'd0, 32'd0, 1'b0);

        for (int i = 0; i < 20; i++)
            beat(8'd0, 32'd1, (i == 19));
        expect_lit("sat", 32'd16, 8'd16, 1'b1);
        nxt(1'b0, 8'd0, 32'd0, 1'b0);

        beat(8'd0, 32'd7, 1'b0);
        beat(8'd0, 32'd8, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        v = 1'b0;
        #1;
        check("midrst.r", o_r, 32'd0);
        check("midrst.c", {24'b0, o_c}, 32'd0);
        check("midrst.e", {31'b0, o_e}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        beat(8'd0, 32'd3, 1'b0);
        beat(8'd0, 32'd4, 1'b1);
        expect_lit("postrst", 32'd7, 8'd2, 1'b0);
        nxt(1'b0, 8'd0, 32'd0, 1'b0);

        for (int p = 0; p < 150; p++) begin
            n = $urandom_range(1, 20);
            if ($urandom_range(0, 9) == 0)
                o0 = 8'($urandom_range(3, 255));
            else
                o0 = 8'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 14) == 0)
                    oi = 8'($urandom_range(0, 2));
                else
                    oi = o0;
                if ($urandom_range(0, 3) == 0)
                    di = $urandom;
                else
                    di = 32'($urandom_range(0, 100));
                if ($urandom_range(0, 3) == 0) idle();
                beat(oi, di, (i == n - 1));
            end
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
